// File: rtl/fft_stage_scheduler.sv
// fft_stage_scheduler
//   Address and strobe sequencer for an in-place radix-2 DIT FFT over N = 2^LOG2N samples
//   held in a dual-port sample RAM. Each stage issues N/2 butterflies, one per cycle. The
//   stage then drains for 1+CU_LATENCY cycles, so its last write-back lands before the next
//   stage reads.
//
// Ports
//   clk                   single clock, rising edge
//   areset_n              asynchronous active-low reset
//   start                 begin a transform; sampled only while idle
//   busy                  high from first issue cycle through last write cycle
//   done                  one-cycle pulse after the final write
//   rd_en                 sample-RAM read strobe (both ports)
//   rd_addr_a, rd_addr_b  butterfly operand addresses
//   tw_addr               twiddle-ROM index, aligned with rd_en
//   wr_en                 sample-RAM write strobe
//   wr_addr_a, wr_addr_b  write-back addresses (read addresses delayed 1+CU_LATENCY cycles)
module fft_stage_scheduler #(
  parameter int unsigned LOG2N      = 4,
  parameter int unsigned CU_LATENCY = 8
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);

  localparam int unsigned KW  = LOG2N - 1;
  localparam int unsigned SW  = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam int unsigned DLY = 1 + CU_LATENCY;
  localparam int unsigned DW  = (DLY > 1) ? $clog2(DLY) : 1;

  localparam logic [KW-1:0] KLast = '1;
  localparam logic [SW-1:0] SLast = SW'(LOG2N - 1);
  localparam logic [DW-1:0] DLast = DW'(DLY - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [KW-1:0] k_q, k_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          s_d     = '0;
          k_d     = '0;
        end
      end
      StIssue: begin
        if (k_q == KLast) begin
          state_d = StDrain;
          dcnt_d  = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDrain: begin
        if (dcnt_q == DLast) begin
          if (s_q == SLast) begin
            state_d = StDone;
          end else begin
            state_d = StIssue;
            s_d     = s_q + 1'b1;
            k_d     = '0;
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Butterfly addressing for the cycle being entered, so the outputs come straight from
  // flops: a = (k with its low s bits kept, upper bits shifted left by one), b = a + 2^s.
  logic             issue_d;
  logic [LOG2N-1:0] kx, h, mask, addr_a_d, addr_b_d;
  logic [KW-1:0]    j;
  logic [SW-1:0]    tsh;
  logic [KW-1:0]    tw_d;

  always_comb begin
    issue_d  = (state_d == StIssue);
    kx       = {1'b0, k_d};
    h        = LOG2N'(1) << s_d;
    mask     = h - 1'b1;
    addr_a_d = ((kx & ~mask) << 1) | (kx & mask);
    addr_b_d = addr_a_d + h;
    j        = k_d & mask[KW-1:0];
    tsh      = SW'(KW) - s_d;
    tw_d     = j << tsh;
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= StIdle;
      s_q       <= '0;
      k_q       <= '0;
      dcnt_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      k_q       <= k_d;
      dcnt_q    <= dcnt_d;
      busy      <= (state_d == StIssue) || (state_d == StDrain);
      done      <= (state_d == StDone);
      rd_en     <= issue_d;
      rd_addr_a <= issue_d ? addr_a_d : '0;
      rd_addr_b <= issue_d ? addr_b_d : '0;
      tw_addr   <= issue_d ? tw_d : '0;
    end
  end

  // Write-back delay line: 1 cycle RAM/ROM read plus CU_LATENCY compute. Addresses are
  // already zero whenever rd_en is low, so the write side inherits that property.
  logic [DLY-1:0]   dl_en_q;
  logic [LOG2N-1:0] dl_a_q [DLY];
  logic [LOG2N-1:0] dl_b_q [DLY];

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      dl_en_q <= '0;
      for (int i = 0; i < DLY; i++) begin
        dl_a_q[i] <= '0;
        dl_b_q[i] <= '0;
      end
    end else begin
      dl_en_q[0] <= rd_en;
      dl_a_q[0]  <= rd_addr_a;
      dl_b_q[0]  <= rd_addr_b;
      for (int i = 1; i < DLY; i++) begin
        dl_en_q[i] <= dl_en_q[i-1];
        dl_a_q[i]  <= dl_a_q[i-1];
        dl_b_q[i]  <= dl_b_q[i-1];
      end
    end
  end

  assign wr_en     = dl_en_q[DLY-1];
  assign wr_addr_a = dl_a_q[DLY-1];
  assign wr_addr_b = dl_b_q[DLY-1];

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Self-checking bench for fft_stage_scheduler. A cycle-accurate expectation model predicts
// the read side. Each predicted read pushes its write-back into a scoreboard queue, which is
// popped when the write is due. A second instance (LOG2N=3, CU_LATENCY=2) covers the small
// configuration.
module tb_fft_stage_scheduler;

  localparam int L1 = 4;
  localparam int C1 = 8;
  localparam int N1 = 1 << L1;
  localparam int D1 = 1 + C1;
  localparam int SL1 = N1 / 2 + D1;
  localparam int TOT1 = L1 * SL1;

  localparam int L2 = 3;
  localparam int C2 = 2;
  localparam int D2 = 1 + C2;
  localparam int SL2 = (1 << L2) / 2 + D2;
  localparam int TOT2 = L2 * SL2;

  logic clk = 1'b0;
  logic areset_n = 1'b0;
  logic start = 1'b0;

  logic          busy, done, rd_en, wr_en;
  logic [L1-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [L1-2:0] tw_addr;

  logic          busy2, done2, rd_en2, wr_en2;
  logic [L2-1:0] rd_addr_a2, rd_addr_b2, wr_addr_a2, wr_addr_b2;
  logic [L2-2:0] tw_addr2;

  fft_stage_scheduler #(.LOG2N(L1), .CU_LATENCY(C1)) dut (
    .clk(clk), .areset_n(areset_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  fft_stage_scheduler #(.LOG2N(L2), .CU_LATENCY(C2)) dut2 (
    .clk(clk), .areset_n(areset_n), .start(start), .busy(busy2), .done(done2),
    .rd_en(rd_en2), .rd_addr_a(rd_addr_a2), .rd_addr_b(rd_addr_b2), .tw_addr(tw_addr2),
    .wr_en(wr_en2), .wr_addr_a(wr_addr_a2), .wr_addr_b(wr_addr_b2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  typedef struct {
    int due;
    int a;
    int b;
  } wr_t;

  wr_t q1[$];

  // Model state for instance 1
  bit run1 = 0;
  int t0_1 = 0;
  int rel, st, off, kk, hh, jj;
  int e_a, e_b, e_tw;
  bit e_rd, e_busy, e_done, e_wr;
  int e_wa, e_wb;

  // Model state for instance 2
  bit run2 = 0;
  int t0_2 = 0;
  int rel2;

  typedef struct {
    logic          en;
    logic [L2-1:0] a;
    logic [L2-1:0] b;
  } hist_t;

  hist_t hist[4];

  always @(negedge clk) begin
    if (!areset_n) begin
      run1 = 0;
      run2 = 0;
      q1.delete();
      for (int i = 0; i < 4; i++) hist[i] = '{en: 1'b0, a: '0, b: '0};
    end

    // ---- instance 1: full expectation model ----
    e_rd = 0; e_busy = 0; e_done = 0; e_a = 0; e_b = 0; e_tw = 0;
    rel = cyc - t0_1;
    if (run1 && rel > TOT1 + 1) run1 = 0;
    if (run1) begin
      if (rel >= 1 && rel <= TOT1) begin
        e_busy = 1;
        st  = (rel - 1) / SL1;
        off = (rel - 1) % SL1;
        if (off < N1 / 2) begin
          e_rd = 1;
          kk   = off;
          hh   = 1 << st;
          jj   = kk % hh;
          e_a  = (kk / hh) * 2 * hh + jj;
          e_b  = e_a + hh;
          e_tw = jj * (1 << (L1 - 1 - st));
        end
      end else if (rel == TOT1 + 1) begin
        e_done = 1;
      end
    end

    e_wr = 0; e_wa = 0; e_wb = 0;
    if (q1.size() > 0 && q1[0].due == cyc) begin
      e_wr = 1;
      e_wa = q1[0].a;
      e_wb = q1[0].b;
      void'(q1.pop_front());
    end
    if (e_rd) q1.push_back('{due: cyc + D1, a: e_a, b: e_b});

    check_eq("busy", busy, e_busy);
    check_eq("done", done, e_done);
    check_eq("rd_en", rd_en, e_rd);
    check_eq("rd_addr_a", rd_addr_a, e_a);
    check_eq("rd_addr_b", rd_addr_b, e_b);
    check_eq("tw_addr", tw_addr, e_tw);
    check_eq("wr_en", wr_en, e_wr);
    check_eq("wr_addr_a", wr_addr_a, e_wa);
    check_eq("wr_addr_b", wr_addr_b, e_wb);

    // ---- instance 2: timing plus write equals read from three cycles earlier ----
    rel2 = cyc - t0_2;
    if (run2 && rel2 > TOT2 + 1) run2 = 0;
    check_eq("s_busy", busy2, run2 && rel2 >= 1 && rel2 <= TOT2);
    check_eq("s_done", done2, run2 && rel2 == TOT2 + 1);
    check_eq("s_wr_en", wr_en2, hist[(cyc + 1) % 4].en);
    check_eq("s_wr_addr_a", wr_addr_a2, hist[(cyc + 1) % 4].a);
    check_eq("s_wr_addr_b", wr_addr_b2, hist[(cyc + 1) % 4].b);
    hist[cyc % 4] = '{en: rd_en2, a: rd_addr_a2, b: rd_addr_b2};

    // Start is sampled at the coming edge only while idle
    if (areset_n && start) begin
      if (!run1) begin run1 = 1; t0_1 = cyc; end
      if (!run2) begin run2 = 1; t0_2 = cyc; end
    end
  end

  task automatic go_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    go_cycle(3);
    areset_n = 1'b1;
    // First run, with stray start pulses that must be ignored
    go_cycle(8);   start = 1'b1;
    go_cycle(9);   start = 1'b0;
    go_cycle(13);  start = 1'b1;
    go_cycle(14);  start = 1'b0;
    go_cycle(48);  start = 1'b1;
    go_cycle(49);  start = 1'b0;
    // Start held high across DONE restarts from IDLE
    go_cycle(82);  start = 1'b1;
    go_cycle(160); start = 1'b0;
    // Reset in the middle of stage 1 of the restarted run
    go_cycle(182); #1 areset_n = 1'b0;
    go_cycle(185); areset_n = 1'b1;
    go_cycle(190); start = 1'b1;
    go_cycle(191); start = 1'b0;
    go_cycle(270);
    check_eq("sb_empty", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
